// File: rtl/sched_table.sv
// Multi-channel time-triggered transmit scheduler.
// Double-buffered slot table; countdown counters per channel.
module sched_table #(
  parameter int NUM_CH    = 4,
  parameter int TB_W      = 16,
  parameter int CYCLE_LEN = 500,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [TB_W-1:0]   cfg_period,
  input  logic [TB_W-1:0]   cfg_offset,
  input  logic              cfg_enable,
  output logic              cfg_err,
  output logic              cfg_pending,
  output logic [TB_W-1:0]   gtb,
  output logic              cycle_start,
  output logic [NUM_CH-1:0] tx
);

  typedef struct packed {
    logic            en;
    logic [TB_W-1:0] per;
    logic [TB_W-1:0] off;
  } ent_t;

  localparam logic [TB_W:0]   CL   = (TB_W+1)'(CYCLE_LEN);
  localparam logic [TB_W-1:0] LAST = TB_W'(CYCLE_LEN - 1);
  localparam logic [31:0]     NCH  = 32'(NUM_CH);

  logic [TB_W-1:0]               gtb_q, gtb_d;
  logic                          cs_q, cs_d;
  logic                          err_q, err_d;
  logic                          pend_q, pend_d;
  logic [NUM_CH-1:0]             tx_q, tx_d;
  ent_t [NUM_CH-1:0]             act_q, act_d;
  ent_t [NUM_CH-1:0]             shd_q, shd_d;
  logic [NUM_CH-1:0][TB_W-1:0]   cnt_q, cnt_d;

  logic              wrap;
  logic              cfg_bad;
  logic              cfg_ok;
  logic [NUM_CH-1:0] due;

  assign wrap    = en & (gtb_q == LAST);
  assign cfg_bad = (32'(cfg_ch) >= NCH)
                 | ({1'b0, cfg_period} >= CL)
                 | ({1'b0, cfg_offset} >= CL);
  assign cfg_ok  = cfg_we & ~cfg_bad;

  always_comb begin
    gtb_d  = gtb_q;
    cs_d   = wrap;
    err_d  = cfg_we & cfg_bad;
    pend_d = pend_q;
    shd_d  = shd_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    due    = '0;
    tx_d   = '0;

    if (en) begin
      gtb_d = wrap ? '0 : gtb_q + TB_W'(1);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ok && cfg_ch == CH_W'(i)) begin
        shd_d[i].en  = cfg_enable;
        shd_d[i].per = cfg_period;
        shd_d[i].off = cfg_offset;
      end
    end

    // Activation copies the pre-write shadow; a same-clk write waits a cycle.
    if (wrap) begin
      act_d  = shd_q;
      pend_d = cfg_ok;
    end else if (cfg_ok) begin
      pend_d = 1'b1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      due[i] = act_q[i].en && (act_q[i].per != '0) && (cnt_q[i] == '0);
      if (wrap) begin
        cnt_d[i] = shd_q[i].off;
      end else if (en) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = (act_q[i].per == '0) ? '0 : act_q[i].per - TB_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i] - TB_W'(1);
        end
      end
    end

    if (en) begin
      tx_d = due;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gtb_q  <= '0;
      cs_q   <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      tx_q   <= '0;
      act_q  <= '0;
      shd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      gtb_q  <= gtb_d;
      cs_q   <= cs_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      tx_q   <= tx_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign gtb         = gtb_q;
  assign cycle_start = cs_q;
  assign cfg_err     = err_q;
  assign cfg_pending = pend_q;
  assign tx          = tx_q;

endmodule

// File: tb/tb_sched_table.sv
// Directed bench for sched_table with CYCLE_LEN=20.
// Per-cycle slot masks and config-error vectors are hand-derived.
module tb_sched_table;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [15:0] cfg_offset;
  logic        cfg_enable;
  logic        cfg_err;
  logic        cfg_pending;
  logic [15:0] gtb;
  logic        cycle_start;
  logic [3:0]  tx;

  int checks = 0;
  int errors = 0;

  sched_table #(
    .NUM_CH(4), .TB_W(16), .CYCLE_LEN(20), .CH_W(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_offset(cfg_offset),
    .cfg_enable(cfg_enable), .cfg_err(cfg_err),
    .cfg_pending(cfg_pending), .gtb(gtb),
    .cycle_start(cycle_start), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  ch;
    logic [15:0] per;
    logic [15:0] off;
    logic        ena;
    logic        err;
    logic        pend;
  } wv_t;

  wv_t        wv [4];
  logic [3:0] mk [4][20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input int p, input int o,
                    input logic e);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = 16'(p);
    cfg_offset = 16'(o);
    cfg_enable = e;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic goto(input int g);
    int n = 0;
    while (int'(gtb) != g && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("goto_timeout", 32'(gtb), 32'(g));
  endtask

  task automatic run(input string nm, input int sel, input int start,
                     input logic ep);
    goto(start);
    for (int k = start; k < 20; k++) begin
      chk({nm, "_gtb"}, 32'(gtb), 32'(k));
      chk({nm, "_pend"}, 32'(cfg_pending), 32'(ep));
      step();
      chk({nm, "_tx"}, 32'(tx), 32'(mk[sel][k]));
      chk({nm, "_cs"}, 32'(cycle_start), 32'(k == 19));
    end
  endtask

  initial begin
    int sp5 [4] = '{0, 5, 10, 15};
    int sp7 [3] = '{0, 7, 14};
    int sc1 [3] = '{3, 9, 15};
    int sc2 [5] = '{3, 7, 11, 15, 19};

    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 20; k++) mk[s][k] = '0;
    foreach (sp5[j]) begin
      mk[1][sp5[j]][0] = 1'b1;
      mk[2][sp5[j]][0] = 1'b1;
    end
    foreach (sp7[j]) mk[3][sp7[j]][0] = 1'b1;
    foreach (sc1[j]) begin
      mk[2][sc1[j]][1] = 1'b1;
      mk[3][sc1[j]][1] = 1'b1;
    end
    foreach (sc2[j]) begin
      mk[2][sc2[j]][2] = 1'b1;
      mk[3][sc2[j]][2] = 1'b1;
    end

    wv[0] = '{"bad_ch",  3'd5, 16'd5,  16'd0,  1'b1, 1'b1, 1'b0};
    wv[1] = '{"bad_per", 3'd1, 16'd20, 16'd3,  1'b1, 1'b1, 1'b0};
    wv[2] = '{"bad_off", 3'd1, 16'd6,  16'd25, 1'b1, 1'b1, 1'b0};
    wv[3] = '{"edge_ok", 3'd3, 16'd19, 16'd19, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_offset = '0; cfg_enable = 1'b0;
    step();
    step();
    chk("rst_gtb", 32'(gtb), 0);
    chk("rst_tx", 32'(tx), 0);
    chk("rst_cs", 32'(cycle_start), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_pend", 32'(cfg_pending), 0);
    rst = 1'b1;

    // 1: single channel, activates after first wrap
    wr(3'd0, 5, 0, 1'b1);
    chk("t1_err", 32'(cfg_err), 0);
    chk("t1_gtb_hold", 32'(gtb), 0);
    en = 1'b1;
    run("t1_idle", 0, 0, 1'b1);
    run("t1", 1, 0, 1'b0);
    run("t1b", 1, 0, 1'b0);

    // 2: two more channels, coincident strobes
    wr(3'd1, 6, 3, 1'b1);
    wr(3'd2, 4, 3, 1'b1);
    chk("t2_pend", 32'(cfg_pending), 1);
    run("t2", 2, 0, 1'b0);

    // 3: mid-cycle rewrite at gtb=8
    goto(8);
    wr(3'd0, 7, 0, 1'b1);
    run("t3_old", 2, 9, 1'b1);
    run("t3_new", 3, 0, 1'b0);

    // 4: rejected writes and an in-range boundary write
    for (int i = 0; i < 4; i++) begin
      wr(wv[i].ch, int'(wv[i].per), int'(wv[i].off), wv[i].ena);
      chk({wv[i].nm, "_err"}, 32'(cfg_err), 32'(wv[i].err));
      chk({wv[i].nm, "_pend"}, 32'(cfg_pending), 32'(wv[i].pend));
      step();
      chk({wv[i].nm, "_err_clr"}, 32'(cfg_err), 0);
      chk({wv[i].nm, "_pend2"}, 32'(cfg_pending), 32'(wv[i].pend));
    end
    run("t4", 3, 0, 1'b0);

    // 5: en gap at gtb=9
    wr(3'd0, 5, 0, 1'b1);
    run("t5a", 2, 0, 1'b0);
    goto(9);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_gtb", 32'(gtb), 9);
      chk("t5_hold_tx", 32'(tx), 0);
      chk("t5_hold_cs", 32'(cycle_start), 0);
    end
    en = 1'b1;
    run("t5b", 2, 9, 1'b0);

    // 6: reset with a pending write
    goto(10);
    wr(3'd2, 4, 0, 1'b1);
    goto(12);
    chk("t6_pend_pre", 32'(cfg_pending), 1);
    rst = 1'b0;
    step();
    chk("t6_gtb", 32'(gtb), 0);
    chk("t6_tx", 32'(tx), 0);
    chk("t6_pend", 32'(cfg_pending), 0);
    chk("t6_cs", 32'(cycle_start), 0);
    rst = 1'b1;
    run("t6a", 0, 0, 1'b0);
    run("t6b", 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sched_table.md
Name: sched_table

Overview:
Multi-channel time-triggered transmit scheduler and parametrised successor to the single-entry scheduler. It owns its own global time base (gtb), which wraps every CYCLE_LEN ticks. It holds a programmable table of NUM_CH entries, each with a period, an offset and an enable, and emits a one-cycle tx strobe per channel on matching slots. Table writes are double-buffered and take effect only at a cycle boundary, so a running schedule never glitches. Per-channel countdown counters replace any modulo arithmetic.

Parameters:
NUM_CH, 4, number of schedule channels (1..32)
TB_W, 16, width of time base, period and offset fields
CYCLE_LEN, 500, gtb wrap length; gtb counts 0..CYCLE_LEN-1 (2..2^TB_W)
CH_W, $clog2(NUM_CH) (min 1), channel index width

Ports:
clk  in  1  clock
rst  in  1  reset
en  in  1  time base advance enable
cfg_we  in  1  table write strobe (single cycle)
cfg_ch  in  CH_W  channel being written
cfg_period  in  TB_W  slot period in ticks; 0 = channel off
cfg_offset  in  TB_W  first slot within the cycle
cfg_enable  in  1  channel enable
cfg_err  out  1  one-cycle pulse: the write was rejected
cfg_pending  out  1  shadow table differs from the active table
gtb  out  TB_W  current time base value
cycle_start  out  1  pulse: gtb wrapped to 0
tx  out  NUM_CH  per-channel transmit strobe

Behaviour:
- Reset rst is synchronous and active-low; clock is clk. On reset: gtb=0, tx=0, cycle_start=0, cfg_err=0, cfg_pending=0. Active and shadow tables clear to period 0, offset 0, disabled.
- Time base:
  - When en=1, gtb increments each clk. At CYCLE_LEN-1 it wraps to 0 and cycle_start pulses high in the cycle where gtb reads 0.
  - When en=0, gtb holds, tx=0 and cycle_start=0. Counters freeze; nothing is lost or skipped.
- Slot rule: channel i is due at gtb value k when all of the following hold:
  - it is active-enabled;
  - period P≠0;
  - k≥O;
  - (k−O) is a multiple of P.
- tx output timing:
  - tx[i] is registered and is high for exactly one cycle, in the cycle after gtb presents a due value k, provided en was 1 when k was presented.
  - Latency from gtb=k to tx is therefore one clk.
  - Multiple channels may strobe in the same cycle; there is no arbitration.
- Slots never carry across the wrap. The phase restarts from O in every cycle. If the last slot of a cycle is close to CYCLE_LEN, the interval to the next cycle's first slot is shorter than P.
- Implementation: each channel has a countdown counter reloaded to O at the wrap and to P−1 after each hit. Synthesising a divider is not permitted.
- Config writes:
  - A write on cfg_we=1 goes to the shadow entry cfg_ch in the following cycle.
  - A write is rejected with cfg_err=1 for one cycle, leaving the shadow unchanged, if any of these hold: cfg_ch≥NUM_CH, cfg_period≥CYCLE_LEN, or cfg_offset≥CYCLE_LEN.
  - Repeated writes to the same channel before a wrap: the last one wins.
- Table activation:
  - The shadow table copies into the active table on the clk where gtb wraps CYCLE_LEN-1→0. Counters are reloaded from the new values, so the first slot evaluated under the new table is gtb=0.
  - If a write and the wrap occur in the same clk, the write lands in the shadow only and activates at the next wrap.
  - cfg_pending=1 from the cycle after an accepted write until the activation clk completes.
- Disabling a channel, or setting period 0, suppresses its tx starting at the next cycle boundary. The current cycle finishes under the old entry.
- Reset mid-cycle: everything returns to reset state immediately. Pending shadow writes are discarded. tx is 0 in the cycle after reset is seen.

Test Plan:
1. CYCLE_LEN=20, NUM_CH=4. Write ch0 P=5 O=0 enable, hold en=1 → tx[0] high the cycle after gtb=0,5,10,15. cycle_start high every 20 clks. No other tx bits toggle.
2. Write ch1 P=6 O=3 and ch2 P=4 O=3 → tx[1] after gtb=3,9,15; tx[2] after gtb=3,7,11,15,19. Both strobe together after gtb=3 and gtb=15.
3. Write ch0 P=7 while gtb=8 → old P=5 slots continue through gtb=15. cfg_pending stays 1 until the wrap. Next cycle: tx[0] after gtb=0,7,14.
4. Write cfg_ch=5, then cfg_period=20, then cfg_offset=25, one write each → cfg_err pulses once per write, the table is unchanged, and cfg_pending stays 0.
5. Drop en for 3 clks at gtb=9 with ch0 P=5 → gtb holds at 9 and tx=0 during the gap. tx[0] follows gtb=10 after resume, with slots at the same gtb values as before the gap.
6. Assert rst=0 at gtb=12 after a pending write → next cycle gtb=0, tx=0, cfg_pending=0. No tx at all after rst returns to 1 until a new config write is made.
